// File: rtl/discharge_pkg.sv
// Shared encodings for the EDM discharge sequencer: FSM state codes, parameter selects, reset defaults.
// Latency: none (constants and a pure helper function only).
// Backpressure: not applicable.
package discharge_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DEAD_IN   = 3'd1;
  localparam logic [2:0] S_WAIT_BD   = 3'd2;
  localparam logic [2:0] S_DISCHARGE = 3'd3;
  localparam logic [2:0] S_DEAD_OUT  = 3'd4;
  localparam logic [2:0] S_DEION     = 3'd5;

  localparam logic [1:0] SEL_TON  = 2'd0;
  localparam logic [1:0] SEL_TOFF = 2'd1;
  localparam logic [1:0] SEL_IP   = 2'd2;

  localparam int TON_DEF  = 10;
  localparam int TOFF_DEF = 50;
  localparam int IP_DEF   = 20;

  // States whose duration is set by the shared pulse timer.
  function automatic logic is_timed(input logic [2:0] s);
    return (s == S_DEAD_IN) || (s == S_DISCHARGE) || (s == S_DEAD_OUT) || (s == S_DEION);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter: an interval of N units, units being cycles or microseconds.
// Latency: done is high in the last cycle of an interval of N*unit cycles counted from the cycle after load.
// Backpressure: none; counting pauses while enable is low, load always wins.
module pulse_timer #(
  parameter int W          = 24,
  parameter int CLK_PER_US = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         load_us,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         done
);

  localparam int PW = $clog2(CLK_PER_US + 1);

  logic [W-1:0]  cnt;
  logic [PW-1:0] pre;
  logic          us;
  logic          tick_us;

  assign tick_us = (pre == PW'(CLK_PER_US - 1));
  assign done    = (cnt == W'(1)) && (!us || tick_us);

  // Count remaining units; the prescaler restarts on every load so each state entry gets full microseconds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pre <= '0;
      us  <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      pre <= '0;
      us  <= load_us;
    end else if (enable) begin
      if (us) begin
        if (tick_us) begin
          pre <= '0;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/discharge_sequencer.sv
// EDM discharge-cycle controller: parameter shadowing, breakdown/short/open classification, Ip hysteresis, gate sequencing.
// Latency: strobes and samples act on state/is_machine/fault one cycle later; gates decode from the registered state.
// Backpressure: none; stop and overcurrent pre-empt every state. Optional counters built with DISCHARGE_STATS_EN.
module discharge_sequencer #(
  parameter int TIMER_W     = 16,
  parameter int SAMPLE_W    = 17,
  parameter int CLK_PER_US  = 100,
  parameter int DEAD_TIME   = 10,
  parameter int WAIT_BD_MIN = 300,
  parameter int WAIT_BD_MAX = 8000,
  parameter int BD_THR_CUR  = 15,
  parameter int BD_THR_VOL  = 30,
  parameter int I_HYST      = 4,
  parameter int MAX_CURRENT = 80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                machine_start,
  input  logic                machine_stop,
  input  logic                param_wr,
  input  logic [1:0]          param_sel,
  input  logic [TIMER_W-1:0]  param_data,
  input  logic [SAMPLE_W-1:0] sample_current,
  input  logic [SAMPLE_W-1:0] sample_voltage,
  output logic [1:0]          mosfet_buck,
  output logic                mosfet_deion,
  output logic                is_machine,
  output logic [2:0]          state,
  output logic                fault
`ifdef DISCHARGE_STATS_EN
 ,output logic [31:0]         pulse_cnt,
  output logic [31:0]         open_cnt,
  output logic [31:0]         short_cnt
`endif
);
  import discharge_pkg::*;

  localparam int TW = TIMER_W + 8;
  localparam int WC = $clog2(WAIT_BD_MAX + 1);
  localparam int CW = ((SAMPLE_W > TIMER_W) ? SAMPLE_W : TIMER_W) + 1;

  logic [2:0]         next_state;
  logic [TIMER_W-1:0] ton_stg, toff_stg, ip_stg;
  logic [TIMER_W-1:0] ton_sh, toff_sh, ip_sh;
  logic [TIMER_W-1:0] ton_eff, toff_eff, ip_hi;
  logic [TIMER_W:0]   ip_sum;
  logic [WC-1:0]      wait_cnt;
  logic [CW-1:0]      cur_mag, vol_mag;
  logic               cur_neg, vol_neg;
  logic               over_cur, cur_bd, vol_low, early, cur_ge_iphi, cur_lt_ip;
  logic               hi_en, bd_evt, open_evt, short_evt;
  logic               tmr_load, tmr_us, tmr_done;
  logic [TW-1:0]      tmr_val;

  // Samples are signed: a negative value is below every threshold, otherwise compare the magnitude unsigned.
  assign cur_neg     = sample_current[SAMPLE_W-1];
  assign vol_neg     = sample_voltage[SAMPLE_W-1];
  assign cur_mag     = CW'(sample_current);
  assign vol_mag     = CW'(sample_voltage);
  assign over_cur    = (state != S_IDLE) && !cur_neg && (cur_mag > CW'(MAX_CURRENT));
  assign cur_bd      = !cur_neg && (cur_mag >= CW'(BD_THR_CUR));
  assign vol_low     = vol_neg || (vol_mag <= CW'(BD_THR_VOL));
  assign early       = (wait_cnt < WC'(WAIT_BD_MIN));
  assign ip_sum      = {1'b0, ip_sh} + (TIMER_W + 1)'(I_HYST);
  assign ip_hi       = ip_sum[TIMER_W] ? '1 : ip_sum[TIMER_W-1:0];
  assign cur_ge_iphi = !cur_neg && (cur_mag >= CW'(ip_hi));
  assign cur_lt_ip   = cur_neg || (cur_mag < CW'(ip_sh));
  assign ton_eff     = (ton_sh == '0) ? TIMER_W'(1) : ton_sh;
  assign toff_eff    = (toff_sh == '0) ? TIMER_W'(1) : toff_sh;

  // Next-state selection; stop and overcurrent abort to IDLE from anywhere.
  always_comb begin
    next_state = state;
    bd_evt     = 1'b0;
    open_evt   = 1'b0;
    short_evt  = 1'b0;
    if (machine_stop || over_cur || (!is_machine && state != S_IDLE)) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (is_machine) next_state = S_DEAD_IN;
        S_DEAD_IN:   if (tmr_done) next_state = S_WAIT_BD;
        S_WAIT_BD: begin
          if (early && vol_low) begin
            short_evt  = 1'b1;
            next_state = S_DEAD_OUT;
          end else if (!early && cur_bd && vol_low) begin
            bd_evt     = 1'b1;
            next_state = S_DISCHARGE;
          end else if (wait_cnt == WC'(WAIT_BD_MAX - 1)) begin
            open_evt   = 1'b1;
            next_state = S_DEAD_OUT;
          end
        end
        S_DISCHARGE: if (tmr_done) next_state = S_DEAD_OUT;
        S_DEAD_OUT:  if (tmr_done) next_state = S_DEION;
        S_DEION:     if (tmr_done) next_state = S_DEAD_IN;
        default:     next_state = S_IDLE;
      endcase
    end
  end

  // Arm the shared timer on entry to each timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_us   = 1'b0;
    tmr_val  = '0;
    if (next_state != state) begin
      case (next_state)
        S_DEAD_IN, S_DEAD_OUT: begin
          tmr_load = 1'b1;
          tmr_val  = TW'(DEAD_TIME);
        end
        S_DISCHARGE: begin
          tmr_load = 1'b1;
          tmr_us   = 1'b1;
          tmr_val  = TW'(ton_eff);
        end
        S_DEION: begin
          tmr_load = 1'b1;
          tmr_us   = 1'b1;
          tmr_val  = TW'(toff_eff);
        end
        default: ;
      endcase
    end
  end

  pulse_timer #(.W(TW), .CLK_PER_US(CLK_PER_US)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_us  (tmr_us),
    .load_val (tmr_val),
    .enable   (is_timed(state)),
    .done     (tmr_done)
  );

  // State register, run/fault latches and the WAIT_BD cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      is_machine <= 1'b0;
      fault      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= (state == S_WAIT_BD) ? wait_cnt + 1'b1 : '0;
      if (over_cur)          fault <= 1'b1;
      else if (machine_stop) fault <= 1'b0;
      if (machine_stop || over_cur)     is_machine <= 1'b0;
      else if (machine_start && !fault) is_machine <= 1'b1;
    end
  end

  // Staged params take host writes; shadows latch on DEAD_IN entry so a cycle never mixes values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ton_stg  <= TIMER_W'(TON_DEF);
      toff_stg <= TIMER_W'(TOFF_DEF);
      ip_stg   <= TIMER_W'(IP_DEF);
      ton_sh   <= TIMER_W'(TON_DEF);
      toff_sh  <= TIMER_W'(TOFF_DEF);
      ip_sh    <= TIMER_W'(IP_DEF);
    end else begin
      if (param_wr) begin
        case (param_sel)
          SEL_TON:  ton_stg  <= param_data;
          SEL_TOFF: toff_stg <= param_data;
          SEL_IP:   ip_stg   <= param_data;
          default:  ;
        endcase
      end
      if (next_state == S_DEAD_IN && state != S_DEAD_IN) begin
        ton_sh  <= ton_stg;
        toff_sh <= toff_stg;
        ip_sh   <= ip_stg;
      end
    end
  end

  // Ip hysteresis: every pulse starts conducting, then drops above Ip+I_HYST and resumes below Ip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       hi_en <= 1'b1;
    else if (state != S_DISCHARGE) hi_en <= 1'b1;
    else if (cur_ge_iphi)          hi_en <= 1'b0;
    else if (cur_lt_ip)            hi_en <= 1'b1;
  end

  // Gate decode: buck-high and deion live in states always separated by a DEAD state.
  always_comb begin
    mosfet_buck  = 2'b00;
    mosfet_deion = 1'b0;
    case (state)
      S_WAIT_BD:   mosfet_buck  = 2'b10;
      S_DISCHARGE: mosfet_buck  = {hi_en, 1'b0};
      S_DEION:     mosfet_deion = 1'b1;
      default:     ;
    endcase
  end

`ifdef DISCHARGE_STATS_EN
  // Saturating event counters, cleared by a start so each run reports its own totals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt <= '0;
      open_cnt  <= '0;
      short_cnt <= '0;
    end else if (machine_start) begin
      pulse_cnt <= '0;
      open_cnt  <= '0;
      short_cnt <= '0;
    end else begin
      if (bd_evt    && pulse_cnt != '1) pulse_cnt <= pulse_cnt + 1'b1;
      if (open_evt  && open_cnt  != '1) open_cnt  <= open_cnt  + 1'b1;
      if (short_evt && short_cnt != '1) short_cnt <= short_cnt + 1'b1;
    end
  end
`else
  // Event counters are not built in this configuration; the events still drive the FSM.
`endif

endmodule

// File: tb/tb_discharge_sequencer.sv
// Self-checking bench for discharge_sequencer: strobe table plus hand-written multi-cycle sequences.
// Drives and samples on the falling edge; all expected values are hand-derived constants.
// Optional counter checks follow DISCHARGE_STATS_EN.
module tb_discharge_sequencer;
  import discharge_pkg::*;

  logic        clk;
  logic        rst;
  logic        machine_start, machine_stop, param_wr;
  logic [1:0]  param_sel;
  logic [15:0] param_data;
  logic [16:0] cur, vol;
  logic [1:0]  mosfet_buck;
  logic        mosfet_deion, is_machine, fault;
  logic [2:0]  state;
`ifdef DISCHARGE_STATS_EN
  logic [31:0] pulse_cnt, open_cnt, short_cnt;
`endif

  int checks;
  int errors;

  discharge_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .machine_start  (machine_start),
    .machine_stop   (machine_stop),
    .param_wr       (param_wr),
    .param_sel      (param_sel),
    .param_data     (param_data),
    .sample_current (cur),
    .sample_voltage (vol),
    .mosfet_buck    (mosfet_buck),
    .mosfet_deion   (mosfet_deion),
    .is_machine     (is_machine),
    .state          (state),
    .fault          (fault)
`ifdef DISCHARGE_STATS_EN
   ,.pulse_cnt      (pulse_cnt),
    .open_cnt       (open_cnt),
    .short_cnt      (short_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic [16:0] cur;
    logic        exp_im;
    logic        exp_fault;
    logic [2:0]  exp_st;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while (state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, state, s);
  endtask

  // Count cycles spent in state s (from the current cycle) and cycles whose gates differ from the expected pattern.
  task automatic run_state(input logic [2:0] s, input logic [1:0] eb, input logic ed,
                           input int limit, output int n, output int bad);
    n = 0;
    bad = 0;
    while (state == s && n < limit) begin
      n++;
      if (mosfet_buck !== eb || mosfet_deion !== ed) bad++;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic st, input logic sp);
    machine_start = st;
    machine_stop  = sp;
    @(negedge clk);
    machine_start = 1'b0;
    machine_stop  = 1'b0;
  endtask

  task automatic pwrite(input logic [1:0] sel, input logic [15:0] data);
    param_wr   = 1'b1;
    param_sel  = sel;
    param_data = data;
    @(negedge clk);
    param_wr   = 1'b0;
  endtask

  // Wait for WAIT_BD, hold open-gap samples for 400 cycles, then present a breakdown.
  task automatic do_breakdown(input string nm);
    wait_state(S_WAIT_BD, 20000, {nm, "_wait"});
    chk({nm, "_wait_buck"}, mosfet_buck, 2'b10);
    repeat (400) @(negedge clk);
    cur = 17'd20;
    vol = 17'd25;
    @(negedge clk);
    chk({nm, "_dis"}, state, S_DISCHARGE);
    vol = 17'd100;
  endtask

  initial begin
    int n, n1, n2, b, b1, b2;
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b1;
    machine_start = 1'b0;
    machine_stop  = 1'b0;
    param_wr      = 1'b0;
    param_sel     = 2'd0;
    param_data    = 16'd0;
    cur = 17'd0;
    vol = 17'd100;

    vecs[0]  = '{1'b1, 1'b0, 17'd0,  1'b1, 1'b0, S_IDLE};
    vecs[1]  = '{1'b0, 1'b0, 17'd0,  1'b1, 1'b0, S_DEAD_IN};
    vecs[2]  = '{1'b1, 1'b1, 17'd0,  1'b0, 1'b0, S_IDLE};
    vecs[3]  = '{1'b0, 1'b0, 17'd85, 1'b0, 1'b0, S_IDLE};
    vecs[4]  = '{1'b1, 1'b0, 17'd0,  1'b1, 1'b0, S_IDLE};
    vecs[5]  = '{1'b0, 1'b0, 17'd0,  1'b1, 1'b0, S_DEAD_IN};
    vecs[6]  = '{1'b0, 1'b0, 17'd85, 1'b0, 1'b1, S_IDLE};
    vecs[7]  = '{1'b1, 1'b0, 17'd0,  1'b0, 1'b1, S_IDLE};
    vecs[8]  = '{1'b0, 1'b1, 17'd0,  1'b0, 1'b0, S_IDLE};
    vecs[9]  = '{1'b1, 1'b0, 17'd0,  1'b1, 1'b0, S_IDLE};
    vecs[10] = '{1'b0, 1'b0, 17'd0,  1'b1, 1'b0, S_DEAD_IN};
    vecs[11] = '{1'b0, 1'b1, 17'd0,  1'b0, 1'b0, S_IDLE};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", state, S_IDLE);
    chk("rst_gates", {mosfet_buck, mosfet_deion}, 3'b000);
    chk("rst_im", is_machine, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_ton", dut.ton_sh, 16'd10);
    chk("rst_toff", dut.toff_sh, 16'd50);
    chk("rst_ip", dut.ip_sh, 16'd20);
`ifdef DISCHARGE_STATS_EN
    chk("rst_pulse_cnt", pulse_cnt, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Strobe table: start/stop priority, overcurrent fault latch, start ignored while faulted
    for (int i = 0; i < 12; i++) begin
      machine_start = vecs[i].start;
      machine_stop  = vecs[i].stop;
      cur           = vecs[i].cur;
      @(negedge clk);
      machine_start = 1'b0;
      machine_stop  = 1'b0;
      chk($sformatf("vec%0d_im", i), is_machine, vecs[i].exp_im);
      chk($sformatf("vec%0d_fault", i), fault, vecs[i].exp_fault);
      chk($sformatf("vec%0d_state", i), state, vecs[i].exp_st);
      chk($sformatf("vec%0d_gates", i), {mosfet_buck, mosfet_deion}, 3'b000);
    end
    cur = 17'd0;

    // Normal cycle, with a Ton=30 write in the middle of the pulse
    pulse(1'b1, 1'b0);
    do_breakdown("normal");
    run_state(S_DISCHARGE, 2'b10, 1'b0, 500, n1, b1);
    pwrite(SEL_TON, 16'd30);
    run_state(S_DISCHARGE, 2'b10, 1'b0, 20000, n2, b2);
    chk("normal_ton_cycles", n1 + 1 + n2, 1000);
    chk("normal_buck_bad", b1 + b2, 0);
    run_state(S_DEAD_OUT, 2'b00, 1'b0, 20000, n, b);
    chk("normal_gap_cycles", n, 10);
    chk("normal_gap_bad", b, 0);
    run_state(S_DEION, 2'b00, 1'b1, 20000, n, b);
    chk("normal_deion_cycles", n, 5000);
    chk("normal_deion_bad", b, 0);
    chk("normal_back_dead_in", state, S_DEAD_IN);

    // Next pulse uses the staged Ton=30; also exercise the Ip hysteresis band (20..24)
    do_breakdown("stage");
    cur = 17'd24;
    @(negedge clk);
    chk("hyst_off_at_24", mosfet_buck, 2'b00);
    cur = 17'd22;
    @(negedge clk);
    chk("hyst_hold_at_22", mosfet_buck, 2'b00);
    cur = 17'd19;
    @(negedge clk);
    chk("hyst_on_at_19", mosfet_buck, 2'b10);
    cur = 17'd20;
    run_state(S_DISCHARGE, 2'b10, 1'b0, 20000, n, b);
    chk("stage_ton_cycles", n + 3, 3000);
    chk("stage_buck_bad", b, 0);

    // Overcurrent during DISCHARGE
    do_breakdown("oc");
    cur = 17'd85;
    @(negedge clk);
    cur = 17'd0;
    chk("oc_state", state, S_IDLE);
    chk("oc_fault", fault, 1'b1);
    chk("oc_im", is_machine, 1'b0);
    chk("oc_gates", {mosfet_buck, mosfet_deion}, 3'b000);
    pulse(1'b1, 1'b0);
    chk("oc_start_ignored", is_machine, 1'b0);
    pulse(1'b0, 1'b1);
    chk("oc_stop_clears", fault, 1'b0);

    // Short circuit: early voltage collapse at WAIT_BD cycle 100
    pulse(1'b1, 1'b0);
    wait_state(S_WAIT_BD, 100, "short_wait");
    repeat (100) @(negedge clk);
    vol = 17'd5;
    @(negedge clk);
    chk("short_dead_out", state, S_DEAD_OUT);
    vol = 17'd100;
`ifdef DISCHARGE_STATS_EN
    chk("short_cnt", short_cnt, 32'd1);
    chk("short_pulse_cnt", pulse_cnt, 32'd0);
`endif

    // Open circuit: voltage stays high, WAIT_BD times out
    wait_state(S_WAIT_BD, 20000, "open_wait");
    run_state(S_WAIT_BD, 2'b10, 1'b0, 20000, n, b);
    chk("open_wait_cycles", n, 8000);
    chk("open_wait_bad", b, 0);
    chk("open_dead_out", state, S_DEAD_OUT);
`ifdef DISCHARGE_STATS_EN
    chk("open_cnt", open_cnt, 32'd1);
    chk("open_short_cnt", short_cnt, 32'd1);
`endif

    // New staged values; reserved select must not disturb Ton
    pwrite(SEL_TON, 16'd7);
    pwrite(SEL_TOFF, 16'd3);
    pwrite(SEL_IP, 16'd50);
    pwrite(2'd3, 16'd999);
    chk("stg_ton_after_rsvd", dut.ton_stg, 16'd7);
    do_breakdown("p7");
    run_state(S_DISCHARGE, 2'b10, 1'b0, 20000, n, b);
    chk("p7_ton_cycles", n, 700);
    run_state(S_DEAD_OUT, 2'b00, 1'b0, 20000, n, b);
    chk("p7_gap_cycles", n, 10);
    run_state(S_DEION, 2'b00, 1'b1, 20000, n, b);
    chk("p7_toff_cycles", n, 300);

    // Reset in the middle of DISCHARGE
    do_breakdown("rstmid");
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_state", state, S_IDLE);
    chk("rstmid_gates", {mosfet_buck, mosfet_deion}, 3'b000);
    chk("rstmid_im", is_machine, 1'b0);
    chk("rstmid_ton", dut.ton_sh, 16'd10);
    chk("rstmid_toff", dut.toff_sh, 16'd50);
    chk("rstmid_ip", dut.ip_sh, 16'd20);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur = 17'd0;
    @(negedge clk);

    // Ton=0 runs as a 1 us pulse
    pwrite(SEL_TON, 16'd0);
    pulse(1'b1, 1'b0);
    do_breakdown("ton0");
    run_state(S_DISCHARGE, 2'b10, 1'b0, 20000, n, b);
    chk("ton0_cycles", n, 100);
    pulse(1'b0, 1'b1);
    chk("final_idle", state, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
